// File: rtl/alien_pkg.sv
// Shared constants, direction type and sprite bitmap for the "alien A" row.
package alien_pkg;

  // Screen and formation geometry, all in 12-bit scan coordinates.
  localparam logic [11:0] H_VISIBLE   = 12'd640;
  localparam logic [11:0] V_VISIBLE   = 12'd480;
  localparam logic [11:0] X0          = 12'd96;
  localparam logic [11:0] Y0          = 12'd64;
  localparam logic [11:0] SPACING     = 12'd96;
  localparam logic [11:0] SCALE       = 12'd2;
  localparam logic [11:0] STEP        = 12'd4;
  localparam logic [11:0] DROP        = 12'd8;
  localparam logic [11:0] LEFT_BOUND  = 12'd16;
  localparam logic [11:0] RIGHT_BOUND = 12'd624;
  localparam logic [11:0] Y_MAX       = 12'd400;

  localparam logic [4:0]  FRAMES_PER_STEP = 5'd30;
  localparam logic [3:0]  COLOR           = 4'hF;
  localparam int          NUM_ALIENS      = 5;

  // Sprite is a 16x8 bitmap replicated SCALE times in each direction.
  localparam int          BMP_W    = 16;
  localparam int          BMP_H    = 8;
  localparam logic [11:0] SPRITE_W = 12'd32;
  localparam logic [11:0] SPRITE_H = 12'd16;

  // Distance from alien 1 left edge to alien 5 right edge (exclusive).
  localparam logic [11:0] FORMATION_W = 12'(4 * SPACING + SPRITE_W);

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  // Two animation frames; bit 15 of each row is the leftmost column.
  localparam logic [0:1][0:BMP_H-1][BMP_W-1:0] ALIEN_BMP = '{
    '{16'h0180, 16'h03C0, 16'h07E0, 16'h0DB0,
      16'h0FF0, 16'h0240, 16'h05A0, 16'h0A50},
    '{16'h0180, 16'h03C0, 16'h07E0, 16'h0DB0,
      16'h0FF0, 16'h05A0, 16'h0810, 16'h0420}
  };

  // Bitmap lookup with dc counted from the left edge of the sprite.
  function automatic logic bmp_lit(input logic       anim,
                                   input logic [2:0] dr,
                                   input logic [3:0] dc);
    return ALIEN_BMP[anim][dr][4'(BMP_W - 1) - dc];
  endfunction

endpackage

// File: rtl/alien_motion.sv
// Formation motion: frame tick detect, step pacing, march, bounce and drop.
module alien_motion
  import alien_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pixel_row,
  input  logic [11:0] pixel_column,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        anim
);

  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  dir_e        dir_q, dir_d;
  logic        anim_q, anim_d;
  logic [4:0]  frame_cnt_q, frame_cnt_d;

  logic        frame_tick;
  logic [11:0] y_dropped;

  // Next-state: count frames, and every FRAMES_PER_STEP frames march or bounce.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    anim_d      = anim_q;
    frame_cnt_d = frame_cnt_q;

    // Column 0 of the first non-visible row occurs exactly once per frame.
    frame_tick = (pixel_row == V_VISIBLE) && (pixel_column == 12'd0);
    y_dropped  = (y_q + DROP > Y_MAX) ? Y_MAX : y_q + DROP;

    if (frame_tick) begin
      if (frame_cnt_q == FRAMES_PER_STEP - 5'd1) begin
        frame_cnt_d = '0;
        anim_d      = ~anim_q;
        if (dir_q == DIR_RIGHT) begin
          if (x_q + STEP + FORMATION_W > RIGHT_BOUND) begin
            dir_d = DIR_LEFT;
            y_d   = y_dropped;
          end else begin
            x_d = x_q + STEP;
          end
        end else begin
          // Comparing against LEFT_BOUND + STEP keeps x_q - STEP from wrapping.
          if (x_q < LEFT_BOUND + STEP) begin
            dir_d = DIR_RIGHT;
            y_d   = y_dropped;
          end else begin
            x_d = x_q - STEP;
          end
        end
      end else begin
        frame_cnt_d = frame_cnt_q + 5'd1;
      end
    end
  end

  // Motion state registers, cleared asynchronously to the start position.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      x_q         <= X0;
      y_q         <= Y0;
      dir_q       <= DIR_RIGHT;
      anim_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      anim_q      <= anim_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign anim = anim_q;

endmodule

// File: rtl/alien_row_sprite.sv
// Row of five animated aliens: hit-test the scan position, look up the
// bitmap and register the pixel and per-alien active flags.
module alien_row_sprite
  import alien_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pixel_row,
  input  logic [11:0] pixel_column,
  output logic [3:0]  alienA_output,
  output logic        alienA1_active,
  output logic        alienA2_active,
  output logic        alienA3_active,
  output logic        alienA4_active,
  output logic        alienA5_active
);

  logic [11:0] x, y;
  logic        anim;

  logic [NUM_ALIENS-1:0] active_q, active_d;
  logic [3:0]            pixel_q, pixel_d;

  logic        row_hit;
  logic [11:0] row_off;
  logic [11:0] xn;
  logic [11:0] col_off;
  logic        col_hit;

  alien_motion u_motion (
    .clk          (clk),
    .rst          (rst),
    .pixel_row    (pixel_row),
    .pixel_column (pixel_column),
    .x            (x),
    .y            (y),
    .anim         (anim)
  );

  // Hit test against each alien box, then the bitmap bit inside the box.
  always_comb begin
    active_d = '0;
    row_off  = '0;
    xn       = '0;
    col_off  = '0;
    col_hit  = 1'b0;

    row_hit = (pixel_row >= y) && (pixel_row < y + SPRITE_H);
    if (row_hit) begin
      row_off = pixel_row - y;
    end

    for (int n = 0; n < NUM_ALIENS; n++) begin
      xn      = x + SPACING * 12'(n);
      col_hit = (pixel_column < H_VISIBLE) && (pixel_column >= xn) &&
                (pixel_column < xn + SPRITE_W);
      col_off = col_hit ? pixel_column - xn : 12'd0;
      if (row_hit && col_hit) begin
        active_d[n] = bmp_lit(anim, 3'(row_off / SCALE), 4'(col_off / SCALE));
      end
    end

    pixel_d = (|active_d) ? COLOR : 4'h0;
  end

  // Output registers give the one-cycle latency that matches the image RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= '0;
      pixel_q  <= 4'h0;
    end else begin
      active_q <= active_d;
      pixel_q  <= pixel_d;
    end
  end

  assign alienA_output  = pixel_q;
  assign alienA1_active = active_q[0];
  assign alienA2_active = active_q[1];
  assign alienA3_active = active_q[2];
  assign alienA4_active = active_q[3];
  assign alienA5_active = active_q[4];

endmodule

// File: tb/tb_alien_row_sprite.sv
// Directed bench for alien_row_sprite: pixel lookup, march, bounce, clamp, reset.
module tb_alien_row_sprite;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pixel_row;
  logic [11:0] pixel_column;
  logic [3:0]  alienA_output;
  logic        a1, a2, a3, a4, a5;

  int errors = 0;
  int checks = 0;

  // Reference model of the formation state.
  int mx = 96, my = 64, mdir = 0, manim = 0, mcnt = 0;

  always #5 clk = ~clk;

  alien_row_sprite dut (
    .clk            (clk),
    .rst            (rst),
    .pixel_row      (pixel_row),
    .pixel_column   (pixel_column),
    .alienA_output  (alienA_output),
    .alienA1_active (a1),
    .alienA2_active (a2),
    .alienA3_active (a3),
    .alienA4_active (a4),
    .alienA5_active (a5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {a5, a4, a3, a2, a1};
  endfunction

  // One scan position, sampled after the registering edge.
  task automatic scan(input int row, input int col);
    @(negedge clk);
    pixel_row    = 12'(row);
    pixel_column = 12'(col);
    @(posedge clk);
    #1;
  endtask

  // Rightmost legal left edge for alien 1 is 208; leftmost is 16.
  task automatic model_tick();
    if (mcnt == 29) begin
      mcnt  = 0;
      manim = 1 - manim;
      if (mdir == 0) begin
        if (mx + 4 > 208) begin
          mdir = 1;
          my   = (my + 8 >= 400) ? 400 : my + 8;
        end else mx = mx + 4;
      end else begin
        if (mx - 4 < 16) begin
          mdir = 0;
          my   = (my + 8 >= 400) ? 400 : my + 8;
        end else mx = mx - 4;
      end
    end else mcnt++;
  endtask

  // Hold the frame-end position for n cycles: n frame ticks.
  task automatic ticks(input int n);
    @(negedge clk);
    pixel_row    = 12'd480;
    pixel_column = 12'd0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_tick();
    end
    @(negedge clk);
    pixel_row    = 12'd0;
    pixel_column = 12'd0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int bounces;
    int prev_dir;

    rst          = 1'b1;
    pixel_row    = 12'd64;
    pixel_column = 12'd110;
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", 32'(flags()), 0);
    check("rst_pixel", 32'(alienA_output), 0);
    check("rst_x", 32'(dut.u_motion.x_q), 96);
    check("rst_y", 32'(dut.u_motion.y_q), 64);

    @(negedge clk);
    rst = 1'b0;

    scan(64, 110);
    check("a1_lit_flags", 32'(flags()), 5'b00001);
    check("a1_lit_pixel", 32'(alienA_output), 15);
    scan(64, 96);
    check("a1_edge_flags", 32'(flags()), 0);
    check("a1_edge_pixel", 32'(alienA_output), 0);
    scan(64, 302);
    check("a3_lit_flags", 32'(flags()), 5'b00100);
    scan(64, 130);
    check("gap_flags", 32'(flags()), 0);
    check("gap_pixel", 32'(alienA_output), 0);

    ticks(30);
    check("step1_x", 32'(dut.u_motion.x_q), 100);
    check("step1_anim", 32'(dut.u_motion.anim_q), 1);
    // Frame 1 row 6 = 16'h0810: dc 4 lit, dc 5 clear (clear in frame 0 too? no: lit there).
    scan(76, 108);
    check("anim1_dc4", 32'(flags()), 5'b00001);
    scan(76, 110);
    check("anim1_dc5", 32'(flags()), 0);

    ticks(29);
    check("hold_x", 32'(dut.u_motion.x_q), 100);

    ticks(1 + 26 * 30);
    check("right_x", 32'(dut.u_motion.x_q), 208);
    check("right_y", 32'(dut.u_motion.y_q), 64);

    ticks(30);
    check("bounce_r_dir", 32'(dut.u_motion.dir_q), 1);
    check("bounce_r_y", 32'(dut.u_motion.y_q), 72);
    check("bounce_r_x", 32'(dut.u_motion.x_q), 208);

    ticks(30);
    check("left1_x", 32'(dut.u_motion.x_q), 204);

    ticks(47 * 30);
    check("left_x", 32'(dut.u_motion.x_q), 16);
    check("left_y", 32'(dut.u_motion.y_q), 72);

    ticks(30);
    check("bounce_l_x", 32'(dut.u_motion.x_q), 16);
    check("bounce_l_y", 32'(dut.u_motion.y_q), 80);
    check("bounce_l_dir", 32'(dut.u_motion.dir_q), 0);

    // March the model and DUT together until the formation hits Y_MAX.
    guard = 0;
    while (my < 400 && guard < 2500) begin
      ticks(30);
      check("march_x", 32'(dut.u_motion.x_q), 32'(mx));
      check("march_y", 32'(dut.u_motion.y_q), 32'(my));
      guard++;
    end
    check("reach_ymax_budget", 32'(guard < 2500), 1);
    check("ymax_y", 32'(dut.u_motion.y_q), 400);

    // Two more bounces must reverse direction without moving y.
    bounces  = 0;
    prev_dir = mdir;
    guard    = 0;
    while (bounces < 2 && guard < 200) begin
      ticks(30);
      if (mdir != prev_dir) begin
        bounces++;
        prev_dir = mdir;
        check("clamp_dir", 32'(dut.u_motion.dir_q), 32'(mdir));
      end
      check("clamp_x", 32'(dut.u_motion.x_q), 32'(mx));
      check("clamp_y", 32'(dut.u_motion.y_q), 400);
      guard++;
    end
    check("clamp_budget", 32'(bounces), 2);

    // Reset while the scan sits on a lit pixel of alien 2.
    scan(400, mx + 96 + 14);
    check("pre_rst_flags", 32'(flags()), 5'b00010);
    check("pre_rst_pixel", 32'(alienA_output), 15);
    rst = 1'b1;
    #1;
    check("mid_rst_flags", 32'(flags()), 0);
    check("mid_rst_pixel", 32'(alienA_output), 0);
    check("mid_rst_x", 32'(dut.u_motion.x_q), 96);
    check("mid_rst_y", 32'(dut.u_motion.y_q), 64);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_x", 32'(dut.u_motion.x_q), 96);
    check("post_rst_y", 32'(dut.u_motion.y_q), 64);
    check("post_rst_flags", 32'(flags()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
